// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// ----------------
// Receive-side VGA timing recovery. Samples hsync/vsync/rgb on the pixel
// clock, rebuilds the pixel coordinates from the sync edges, verifies line
// and frame lengths, and locks once a complete frame has been verified.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   hsync      horizontal sync input, active low
//   vsync      vertical sync input, active low
//   rgb[5:0]   pixel data input
//   col[9:0]   recovered column of pix_rgb
//   row[9:0]   recovered row of pix_rgb
//   pix_valid  pix_rgb is a visible pixel and the decoder is locked
//   pix_rgb    registered pixel data (two cycles behind the pins)
//   frame_tick one-cycle pulse per verified frame while locked
//   locked     high in the LOCKED state
//   err_count  saturating count of lock losses
//   frame_crc  CRC-16-CCITT of the previous frame's visible pixels
//
// Build option: define VGA_DEC_CRC_EN to build the frame CRC. Without it,
// frame_crc is tied to zero and no CRC logic exists.
module vga_sync_decoder #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rgb,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        pix_valid,
  output logic [5:0]  pix_rgb,
  output logic        frame_tick,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_OVER  = 11'(H_TOTAL);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0] V_LINES = 11'(V_TOTAL);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t      state, state_next;

  // Input stage: one capture register plus one edge-detect register.
  logic        hs_r, hs_rr, vs_r, vs_rr;
  logic [5:0]  rgb_r;

  logic [10:0] hcnt, hcnt_next;
  logic [9:0]  vcnt, vcnt_next;
  logic        vpend, vpend_next, vpend_eff;
  logic [9:0]  lcnt;           // hsync edges since the last vsync edge
  logic [10:0] lines_closed;

  logic        hs_edge, vs_edge;
  logic        line_bad, frame_bad, mismatch;
  logic        h_act, v_act;

  always_comb begin
    hs_edge   = hs_rr & ~hs_r;
    vs_edge   = vs_rr & ~vs_r;

    hcnt_next = (hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1;
    if (hs_edge) begin
      hcnt_next = '0;
    end

    // A vsync edge in the same cycle as an hsync edge restarts the row
    // count immediately rather than waiting a line.
    vpend_eff  = vpend | vs_edge;
    vpend_next = vpend_eff;
    vcnt_next  = vcnt;
    if (hs_edge) begin
      vpend_next = 1'b0;
      if (vpend_eff) begin
        vcnt_next = '0;
      end else if (vcnt != 10'h3FF) begin
        vcnt_next = vcnt + 10'd1;
      end
    end

    // A line is short if the edge arrives early, long once hcnt reaches
    // the line total without an edge (flagged once, at exactly H_TOTAL).
    line_bad     = hs_edge ? (hcnt != H_LAST) : (hcnt == H_OVER);
    // The hsync edge coincident with the closing vsync edge belongs to
    // the frame being closed.
    lines_closed = {1'b0, lcnt} + {10'd0, hs_edge};
    frame_bad    = vs_edge && (lines_closed != V_LINES);
    mismatch     = line_bad | frame_bad;

    h_act = (hcnt_next >= H_START) && (hcnt_next <= H_END);
    v_act = (vcnt_next >= V_START) && (vcnt_next <= V_END);

    state_next = state;
    case (state)
      ST_SEARCH: begin
        if (vs_edge) state_next = ST_VERIFY;
      end
      ST_VERIFY: begin
        if (mismatch)     state_next = ST_SEARCH;
        else if (vs_edge) state_next = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (mismatch) state_next = ST_SEARCH;
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_r       <= 1'b1;
      hs_rr      <= 1'b1;
      vs_r       <= 1'b1;
      vs_rr      <= 1'b1;
      rgb_r      <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      vpend      <= 1'b0;
      lcnt       <= '0;
      state      <= ST_SEARCH;
      col        <= '0;
      row        <= '0;
      pix_valid  <= 1'b0;
      pix_rgb    <= '0;
      frame_tick <= 1'b0;
      err_count  <= '0;
    end else begin
      hs_r  <= hsync;
      hs_rr <= hs_r;
      vs_r  <= vsync;
      vs_rr <= vs_r;
      rgb_r <= rgb;

      hcnt  <= hcnt_next;
      vcnt  <= vcnt_next;
      vpend <= vpend_next;
      state <= state_next;

      if (vs_edge) begin
        lcnt <= '0;
      end else if (hs_edge && lcnt != 10'h3FF) begin
        lcnt <= lcnt + 10'd1;
      end

      // Coordinates are taken from the next-cycle counters so that they
      // line up with pix_rgb, which is two cycles behind the pins.
      pix_rgb   <= rgb_r;
      pix_valid <= (state_next == ST_LOCKED) && h_act && v_act;
      if (h_act && v_act) begin
        col <= 10'(hcnt_next - H_START);
        row <= vcnt_next - V_START;
      end

      // Only a good closing edge can leave the FSM in LOCKED on a vsync
      // edge, so this covers both lock entry and each locked frame.
      frame_tick <= vs_edge && (state_next == ST_LOCKED);

      if (state == ST_LOCKED && mismatch && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_acc;

  // CRC-16-CCITT, poly 0x1021, one byte MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    end
    return x;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vs_edge) begin
      frame_crc <= crc_acc;
      crc_acc   <= 16'hFFFF;
    end else if (pix_valid) begin
      crc_acc <= crc_byte(crc_acc, {2'b00, pix_rgb});
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder using a reduced raster
// (16x8 visible, 25x15 total) so every scenario fits in a few frames.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam int NONE = 9999;
`ifdef VGA_DEC_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, hsync, vsync;
  logic [5:0]  rgb;
  logic [9:0]  col, row;
  logic        pix_valid, frame_tick, locked;
  logic [5:0]  pix_rgb;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .col(col), .row(row), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .frame_tick(frame_tick), .locked(locked), .err_count(err_count),
    .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ticks = 0;
  int          exp_ticks = 0;
  int          exp_err = 0;
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;
  bit          crc_ok = 1'b0;
  logic [15:0] crc_prev = 16'hFFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] x;
    x = c ^ {2'b00, d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    end
    return x;
  endfunction

  function automatic logic [5:0] pat_px(input int pat, input int c, input int r);
    case (pat)
      1:       return 6'h00;
      2:       return 6'h3F;
      default: return 6'((c ^ r) & 63);
    endcase
  endfunction

  task automatic check_reset_vals();
    check("rst_col", 32'(col), 0);
    check("rst_row", 32'(row), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_rgb", 32'(pix_rgb), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_frame_crc", 32'(frame_crc), 0);
  endtask

  // Monitor: pops one expected pixel whenever the DUT presents pix_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (pix_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: got col=%0d row=%0d rgb=0x%0h expected no pixel",
                   col, row, pix_rgb);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel{col,row,rgb}", 32'({col, row, pix_rgb}), 32'(mon_e));
        end
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        check("tick_with_locked", 32'(locked), 1);
      end
    end
  end

  // One frame of pin activity. lk: decoder expected locked at frame start.
  // short_line: that line is one clock short. rst_line: rst pulsed at its h=0.
  task automatic gen_frame(input bit lk, input int n_lines, input int short_line,
                           input int rst_line, input int pat);
    logic [15:0] crc;
    bit          clean;
    bit          act;
    int          len;
    logic [5:0]  px;
    crc   = 16'hFFFF;
    clean = lk && (n_lines == VT) && (short_line >= n_lines) && (rst_line >= n_lines);
    if (lk) exp_ticks++;
    for (int v = 0; v < n_lines; v++) begin
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(negedge clk);
        if (v == 0 && h == 3 && crc_ok)
          check("frame_crc", 32'(frame_crc), CRC_ON ? 32'(crc_prev) : 32'd0);
        if (lk && v == short_line + 1 && h == 1) check("lock_before_drop", 32'(locked), 1);
        if (lk && v == short_line + 1 && h == 2) check("lock_drop", 32'(locked), 0);
        if (v == rst_line && h == 1) check_reset_vals();
        rst   = (v == rst_line && h == 0);
        hsync = !(h < HS);
        vsync = !(v < VS);
        act   = (v >= VST) && (v < VST + VA) && (h >= HST) && (h < HST + HA);
        if (act) begin
          px  = pat_px(pat, h - HST, v - VST);
          rgb = px;
          if (lk && v <= short_line && v < rst_line) begin
            exp_q.push_back({10'(h - HST), 10'(v - VST), px});
            crc = crc_upd(crc, px);
          end
        end else begin
          rgb = 6'h2A;
        end
      end
    end
    if (rst_line < n_lines) exp_err = 0;
    else if (lk && short_line < n_lines) exp_err++;
    check("frame_ticks", 32'(ticks), 32'(exp_ticks));
    check("frame_end_locked", 32'(locked), 32'(clean));
    check("frame_err_count", 32'(err_count), 32'(exp_err));
    check("queue_drained", 32'(exp_q.size()), 0);
    crc_ok   = clean;
    crc_prev = crc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Nominal: first vsync edge verifies, second locks.
    gen_frame(1'b0, VT, NONE, NONE, 0);
    gen_frame(1'b1, VT, NONE, NONE, 0);
    gen_frame(1'b1, VT, NONE, NONE, 0);

    // One line a clock short while locked, then relock.
    gen_frame(1'b1, VT, 7, NONE, 0);
    gen_frame(1'b0, VT, NONE, NONE, 0);
    gen_frame(1'b1, VT, NONE, NONE, 0);

    // Reset mid-frame while locked, then relock.
    gen_frame(1'b1, VT, NONE, 7, 0);
    gen_frame(1'b0, VT, NONE, NONE, 0);
    gen_frame(1'b1, VT, NONE, NONE, 0);

    // Fresh reset, then a frame one line short while verifying.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0; exp_err = 0; crc_ok = 1'b0;
    @(negedge clk);
    gen_frame(1'b0, VT - 1, NONE, NONE, 0);
    gen_frame(1'b0, VT, NONE, NONE, 0);
    gen_frame(1'b0, VT, NONE, NONE, 0);
    gen_frame(1'b1, VT, NONE, NONE, 0);

    // Flat frames: CRC of all-zero and all-0x3F frames, each seen twice.
    gen_frame(1'b1, VT, NONE, NONE, 1);
    gen_frame(1'b1, VT, NONE, NONE, 2);
    gen_frame(1'b1, VT, NONE, NONE, 2);
    gen_frame(1'b1, VT, NONE, NONE, 1);
    gen_frame(1'b1, VT, NONE, NONE, 0);

    // hsync stuck high while locked.
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (i == 2) check("stuck_lock_hold", 32'(locked), 1);
      if (i == 3) check("stuck_lock_drop", 32'(locked), 0);
      hsync = 1'b1; vsync = 1'b1; rgb = '0;
    end
    exp_err++;
    check("stuck_err_count", 32'(err_count), 32'(exp_err));
    check("stuck_hcnt_saturated", 32'(dut.hcnt), 2047);
    check("stuck_pix_valid", 32'(pix_valid), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
